// File: rtl/flexbex_efpga_accel_responder.sv
// Stand-in eFPGA custom-instruction responder: latches operands on strobe, computes ADD/MUL/MAC/CLEAR,
// done after max(L_op+EXTRA_WAIT, delay, 1) cycles; no backpressure, en_i low aborts BUSY or releases DONE.
module flexbex_efpga_accel_responder #(
    parameter int unsigned EXTRA_WAIT = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        eFPGA_en_i,
    input  logic        eFPGA_write_strobe_i,
    input  logic [1:0]  eFPGA_operator_i,
    input  logic [31:0] eFPGA_operand_a_i,
    input  logic [31:0] eFPGA_operand_b_i,
    input  logic [3:0]  eFPGA_delay_i,
    output logic [31:0] eFPGA_result_a_o,
    output logic [31:0] eFPGA_result_b_o,
    output logic [31:0] eFPGA_result_c_o,
    output logic        eFPGA_fpga_done_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_MUL = 2'b01;
    localparam logic [1:0] OP_MAC = 2'b10;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [1:0]  op_q, op_d;
    logic [3:0]  dly_q, dly_d;
    logic [63:0] mcand_q, mcand_d;
    logic [31:0] mplier_q, mplier_d;
    logic [63:0] prod_q, prod_d;
    logic [31:0] mac_prod_q, mac_prod_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] nmac_q, nmac_d;
    logic [31:0] res_a_q, res_a_d;
    logic [31:0] res_b_q, res_b_d;
    logic [31:0] res_c_q, res_c_d;

    logic [5:0]  lat_op;
    logic [5:0]  lat;
    logic [63:0] prod_step;
    logic [31:0] mac_mul;

    // Every L_op is at least 1, so the lower clamp of the latency is implicit.
    always_comb begin
        case (op_q)
            OP_MUL:  lat_op = 6'd32;
            OP_MAC:  lat_op = 6'd2;
            default: lat_op = 6'd1;
        endcase
        lat = lat_op + 6'(EXTRA_WAIT);
        if ({2'b00, dly_q} > lat) begin
            lat = {2'b00, dly_q};
        end
    end

    // Once the multiplier has shifted out, the step adds zero, so padding cycles are harmless.
    assign prod_step = prod_q + (mplier_q[0] ? mcand_q : 64'd0);
    assign mac_mul   = {16'b0, a_q[15:0]} * {16'b0, b_q[15:0]};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        dly_d      = dly_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        prod_d     = prod_q;
        mac_prod_d = mac_prod_q;
        acc_d      = acc_q;
        nmac_d     = nmac_q;
        res_a_d    = res_a_q;
        res_b_d    = res_b_q;
        res_c_d    = res_c_q;

        case (state_q)
            IDLE: begin
                if (eFPGA_write_strobe_i && eFPGA_en_i) begin
                    state_d  = BUSY;
                    cnt_d    = 6'd1;
                    a_d      = eFPGA_operand_a_i;
                    b_d      = eFPGA_operand_b_i;
                    op_d     = eFPGA_operator_i;
                    dly_d    = eFPGA_delay_i;
                    mcand_d  = {32'b0, eFPGA_operand_a_i};
                    mplier_d = eFPGA_operand_b_i;
                    prod_d   = 64'd0;
                end
            end
            BUSY: begin
                if (!eFPGA_en_i) begin
                    state_d = IDLE;
                end else begin
                    cnt_d    = cnt_q + 6'd1;
                    prod_d   = prod_step;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    if (cnt_q == 6'd1) begin
                        mac_prod_d = mac_mul;
                    end
                    if (cnt_q == lat) begin
                        state_d = DONE;
                        case (op_q)
                            OP_ADD: begin
                                res_a_d = a_q + b_q;
                                res_b_d = a_q - b_q;
                                res_c_d = {31'b0, a_q < b_q};
                            end
                            OP_MUL: begin
                                res_a_d = prod_step[31:0];
                                res_b_d = prod_step[63:32];
                                res_c_d = 32'd32;
                            end
                            OP_MAC: begin
                                acc_d   = acc_q + mac_prod_q;
                                nmac_d  = nmac_q + 32'd1;
                                res_a_d = acc_q + mac_prod_q;
                                res_b_d = acc_q;
                                res_c_d = nmac_q + 32'd1;
                            end
                            default: begin
                                acc_d   = 32'd0;
                                nmac_d  = 32'd0;
                                res_a_d = 32'd0;
                                res_b_d = 32'd0;
                                res_c_d = 32'd0;
                            end
                        endcase
                    end
                end
            end
            DONE: begin
                if (!eFPGA_en_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= 6'd0;
            a_q        <= 32'd0;
            b_q        <= 32'd0;
            op_q       <= 2'd0;
            dly_q      <= 4'd0;
            mcand_q    <= 64'd0;
            mplier_q   <= 32'd0;
            prod_q     <= 64'd0;
            mac_prod_q <= 32'd0;
            acc_q      <= 32'd0;
            nmac_q     <= 32'd0;
            res_a_q    <= 32'd0;
            res_b_q    <= 32'd0;
            res_c_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            dly_q      <= dly_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            prod_q     <= prod_d;
            mac_prod_q <= mac_prod_d;
            acc_q      <= acc_d;
            nmac_q     <= nmac_d;
            res_a_q    <= res_a_d;
            res_b_q    <= res_b_d;
            res_c_q    <= res_c_d;
        end
    end

    assign eFPGA_result_a_o  = res_a_q;
    assign eFPGA_result_b_o  = res_b_q;
    assign eFPGA_result_c_o  = res_c_q;
    assign eFPGA_fpga_done_o = (state_q == DONE);

endmodule

// File: tb/tb_flexbex_efpga_accel_responder.sv
// Bench for flexbex_efpga_accel_responder: directed table, multi-cycle corner sequences, random ops vs model.
module tb_flexbex_efpga_accel_responder;

    logic        clk = 1'b0;
    logic        rst, en, stb;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic [3:0]  dly;
    logic [31:0] ra0, rb0, rc0, ra1, rb1, rc1;
    logic        done0, done1;

    always #5 clk = ~clk;

    flexbex_efpga_accel_responder #(.EXTRA_WAIT(0)) dut0 (
        .clk_i(clk), .rst_i(rst), .eFPGA_en_i(en), .eFPGA_write_strobe_i(stb),
        .eFPGA_operator_i(op), .eFPGA_operand_a_i(a), .eFPGA_operand_b_i(b),
        .eFPGA_delay_i(dly), .eFPGA_result_a_o(ra0), .eFPGA_result_b_o(rb0),
        .eFPGA_result_c_o(rc0), .eFPGA_fpga_done_o(done0)
    );

    flexbex_efpga_accel_responder #(.EXTRA_WAIT(3)) dut1 (
        .clk_i(clk), .rst_i(rst), .eFPGA_en_i(en), .eFPGA_write_strobe_i(stb),
        .eFPGA_operator_i(op), .eFPGA_operand_a_i(a), .eFPGA_operand_b_i(b),
        .eFPGA_delay_i(dly), .eFPGA_result_a_o(ra1), .eFPGA_result_b_o(rb1),
        .eFPGA_result_c_o(rc1), .eFPGA_fpga_done_o(done1)
    );

    int total = 0;
    int bad   = 0;

    // Reference state: accumulator, MAC count and last committed results of dut0.
    logic [31:0] m_acc, m_nmac, m_ra, m_rb, m_rc;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  dly;
        logic [31:0] ea;
        logic [31:0] eb;
        logic [31:0] ec;
        int          lat;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    function automatic int lat_of(input logic [1:0] o, input logic [3:0] d, input int ew);
        int l;
        l = (o == 2'b01) ? 32 : (o == 2'b10) ? 2 : 1;
        l = l + ew;
        if (int'(d) > l) l = int'(d);
        if (l < 1) l = 1;
        return l;
    endfunction

    task automatic model_commit(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] ea, output logic [31:0] eb, output logic [31:0] ec);
        logic [63:0] p;
        logic [31:0] mp;
        case (o)
            2'b00: begin
                ea = x + y;
                eb = x - y;
                ec = (x < y) ? 32'd1 : 32'd0;
            end
            2'b01: begin
                p  = {32'b0, x} * {32'b0, y};
                ea = p[31:0];
                eb = p[63:32];
                ec = 32'd32;
            end
            2'b10: begin
                mp     = {16'b0, x[15:0]} * {16'b0, y[15:0]};
                eb     = m_acc;
                m_acc  = m_acc + mp;
                m_nmac = m_nmac + 32'd1;
                ea     = m_acc;
                ec     = m_nmac;
            end
            default: begin
                m_acc  = 32'd0;
                m_nmac = 32'd0;
                ea = 32'd0;
                eb = 32'd0;
                ec = 32'd0;
            end
        endcase
    endtask

    task automatic start_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                            input logic [3:0] d);
        op = o; a = x; b = y; dly = d; en = 1'b1; stb = 1'b1;
        @(negedge clk);
        stb = 1'b0;
    endtask

    // inj_busy: cycle index at which a stray strobe is pulsed while BUSY (-1 = none).
    task automatic do_op(input string nm, input logic [1:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [3:0] d, input int lat,
                         input logic [31:0] ea, input logic [31:0] eb, input logic [31:0] ec,
                         input bit ew, input int inj_busy, input bit inj_done);
        int k;
        bit seen;
        k = 0;
        seen = 1'b0;
        start_op(o, x, y, d);
        while (!seen && k < 100) begin
            if (k == inj_busy) begin
                stb = 1'b1; op = ~o; a = $urandom; b = $urandom; dly = 4'd0;
            end
            @(negedge clk);
            stb = 1'b0;
            k++;
            seen = ew ? done1 : done0;
        end
        chk({nm, " latency"}, 32'(k), 32'(lat));
        chk({nm, " res_a"}, ew ? ra1 : ra0, ea);
        chk({nm, " res_b"}, ew ? rb1 : rb0, eb);
        chk({nm, " res_c"}, ew ? rc1 : rc0, ec);
        if (inj_done) begin
            stb = 1'b1; op = ~o; a = $urandom; b = $urandom;
            @(negedge clk);
            stb = 1'b0;
            @(negedge clk);
            chk({nm, " done held"}, {31'b0, done0}, 32'd1);
            chk({nm, " res_a held"}, ra0, ea);
        end
        en = 1'b0;
        @(negedge clk);
        chk({nm, " done fall"}, {31'b0, ew ? done1 : done0}, 32'd0);
        m_ra = ea; m_rb = eb; m_rc = ec;
    endtask

    // en is dropped at cycle index kd; the edge after samples it low.
    task automatic do_abort(input string nm, input logic [1:0] o, input logic [31:0] x,
                            input logic [31:0] y, input logic [3:0] d, input int kd);
        bit seen;
        seen = 1'b0;
        start_op(o, x, y, d);
        for (int k = 0; k < kd + 3; k++) begin
            if (k == kd) en = 1'b0;
            @(negedge clk);
            if (done0) seen = 1'b1;
        end
        chk({nm, " done seen"}, {31'b0, seen}, 32'd0);
        chk({nm, " res_a"}, ra0, m_ra);
        chk({nm, " res_b"}, rb0, m_rb);
        chk({nm, " res_c"}, rc0, m_rc);
    endtask

    initial begin
        logic [1:0]  o;
        logic [31:0] x, y, ea, eb, ec;
        logic [3:0]  d;
        int          l;

        tbl[0] = '{2'b00, 32'hFFFF_FFFF, 32'd2,        4'd0,  32'h1,          32'hFFFF_FFFD, 32'd0,  1};
        tbl[1] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd0, 32'h1,          32'hFFFF_FFFE, 32'd32, 32};
        tbl[2] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd15, 32'h1,         32'hFFFF_FFFE, 32'd32, 32};
        tbl[3] = '{2'b00, 32'd5,         32'd7,        4'd9,  32'd12,         32'hFFFF_FFFE, 32'd1,  9};
        tbl[4] = '{2'b11, 32'd77,        32'd88,       4'd0,  32'd0,          32'd0,         32'd0,  1};
        tbl[5] = '{2'b10, 32'd3,         32'd4,        4'd0,  32'd12,         32'd0,         32'd1,  2};
        tbl[6] = '{2'b10, 32'h0001_0005, 32'd2,        4'd0,  32'd22,         32'd12,        32'd2,  2};
        tbl[7] = '{2'b01, 32'h1234_5678, 32'h10,       4'd0,  32'h2345_6780,  32'd1,         32'd32, 32};
        tbl[8] = '{2'b00, 32'd3,         32'd3,        4'd0,  32'd6,          32'd0,         32'd0,  1};

        m_acc = 0; m_nmac = 0; m_ra = 0; m_rb = 0; m_rc = 0;
        rst = 1'b1; en = 1'b0; stb = 1'b0; op = 2'b00; a = 0; b = 0; dly = 0;
        repeat (2) @(negedge clk);
        chk("reset res_a", ra0, 32'd0);
        chk("reset res_b", rb0, 32'd0);
        chk("reset res_c", rc0, 32'd0);
        chk("reset done", {31'b0, done0}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            model_commit(tbl[i].op, tbl[i].a, tbl[i].b, ea, eb, ec);
            do_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].dly, tbl[i].lat,
                  tbl[i].ea, tbl[i].eb, tbl[i].ec, 1'b0, -1, 1'b0);
        end

        do_abort("abort_mul", 2'b01, 32'd7, 32'd9, 4'd0, 10);
        model_commit(2'b00, 32'd1, 32'd1, ea, eb, ec);
        do_op("add_after_abort", 2'b00, 32'd1, 32'd1, 4'd0, 1, 32'd2, 32'd0, 32'd0, 1'b0, -1, 1'b0);

        do_abort("abort_at_L_add", 2'b00, 32'd9, 32'd9, 4'd5, 4);
        do_abort("abort_at_L_mac", 2'b10, 32'd100, 32'd100, 4'd0, 1);
        model_commit(2'b10, 32'd2, 32'd3, ea, eb, ec);
        do_op("mac_after_abort", 2'b10, 32'd2, 32'd3, 4'd0, 2, ea, eb, ec, 1'b0, -1, 1'b0);

        model_commit(2'b01, 32'h0001_0000, 32'h0001_0000, ea, eb, ec);
        do_op("stray_strobes", 2'b01, 32'h0001_0000, 32'h0001_0000, 4'd0, 32, 32'd0, 32'd1, 32'd32,
              1'b0, 5, 1'b1);

        en = 1'b0; stb = 1'b1; op = 2'b00; a = 32'd5; b = 32'd5;
        @(negedge clk);
        stb = 1'b0;
        repeat (3) @(negedge clk);
        chk("no_en_strobe done", {31'b0, done0}, 32'd0);
        chk("no_en_strobe res_a", ra0, m_ra);
        model_commit(2'b00, 32'd2, 32'd2, ea, eb, ec);
        do_op("add_after_no_en", 2'b00, 32'd2, 32'd2, 4'd0, 1, 32'd4, 32'd0, 32'd0, 1'b0, -1, 1'b0);

        model_commit(2'b00, 32'd10, 32'd3, ea, eb, ec);
        do_op("extra_wait", 2'b00, 32'd10, 32'd3, 4'd0, 4, 32'd13, 32'd7, 32'd0, 1'b1, -1, 1'b0);
        model_commit(2'b00, 32'd1, 32'd2, ea, eb, ec);
        do_op("extra_wait_dly6", 2'b00, 32'd1, 32'd2, 4'd6, 6, 32'd3, 32'hFFFF_FFFF, 32'd1,
              1'b1, -1, 1'b0);

        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom_range(0, 3));
            x = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 999));
            y = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 999));
            d = 4'($urandom_range(0, 15));
            l = lat_of(o, d, 0);
            if ($urandom_range(0, 4) == 0) begin
                do_abort($sformatf("rnd_abort%0d", i), o, x, y, d, $urandom_range(0, l - 1));
            end else begin
                model_commit(o, x, y, ea, eb, ec);
                do_op($sformatf("rnd%0d", i), o, x, y, d, l, ea, eb, ec, 1'b0, -1, 1'b0);
            end
        end

        model_commit(2'b00, 32'd4, 32'd4, ea, eb, ec);
        do_op("pre_reset_add", 2'b00, 32'd4, 32'd4, 4'd0, 1, 32'd8, 32'd0, 32'd0, 1'b0, -1, 1'b0);
        start_op(2'b01, 32'hFFFF_FFFF, 32'd3, 4'd0);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midop_reset res_a", ra0, 32'd0);
        chk("midop_reset res_b", rb0, 32'd0);
        chk("midop_reset res_c", rc0, 32'd0);
        chk("midop_reset done", {31'b0, done0}, 32'd0);
        m_acc = 0; m_nmac = 0; m_ra = 0; m_rb = 0; m_rc = 0;
        @(negedge clk);
        rst = 1'b0;
        en = 1'b0;
        @(negedge clk);
        model_commit(2'b10, 32'd1, 32'd1, ea, eb, ec);
        do_op("mac_after_reset", 2'b10, 32'd1, 32'd1, 4'd0, 2, 32'd1, 32'd0, 32'd1, 1'b0, -1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
